// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner
//   Drives the select of a registered 4:1 channel mux. After a start it dwells a
//   programmable number of cycles on each enabled channel in ascending round-robin
//   order, for a programmed number of sweeps (or until stop). Each dwell produces
//   one sample strobe whose channel tag is delayed by MUX_LAT cycles. The delay
//   lines the strobe up with the mux's registered output.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      1-cycle scan request, honoured only while idle with chan_en != 0
//   stop       end the scan after the current dwell
//   chan_en    channel enable mask (bit n = mux channel n), latched on start
//   dwell      cycles per channel, latched on start, 0 behaves as 1
//   passes     sweeps to run, latched on start, 0 = run until stop
//   sel        channel select to the mux
//   busy       high while scanning or draining the tag pipeline
//   samp_valid mux output holds channel samp_ch this cycle
//   samp_ch    channel tag for samp_valid
//   pass_done  1-cycle pulse after the last dwell of each full sweep
//   done       1-cycle pulse once the scan has ended and the last sample is out
module mux_sel_scanner #(
    parameter int DWELL_W  = 8,
    parameter int PASSES_W = 4,
    parameter int MUX_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [3:0]          chan_en,
    input  logic [DWELL_W-1:0]  dwell,
    input  logic [PASSES_W-1:0] passes,
    output logic [1:0]          sel,
    output logic                busy,
    output logic                samp_valid,
    output logic [1:0]          samp_ch,
    output logic                pass_done,
    output logic                done
);

    localparam int                  DRAIN_W    = (MUX_LAT > 1) ? $clog2(MUX_LAT) : 1;
    localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'(MUX_LAT - 1);
    localparam logic [DRAIN_W-1:0]  DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [DWELL_W-1:0]  DWELL_ONE  = DWELL_W'(1);
    localparam logic [PASSES_W-1:0] PASS_ONE   = PASSES_W'(1);
    localparam logic [PASSES_W-1:0] PASS_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [3:0]          mask_reg;
    logic [DWELL_W-1:0]  dwell_len_reg;
    logic [DWELL_W-1:0]  dwell_cnt_reg;
    logic [PASSES_W-1:0] passes_reg;
    logic [PASSES_W-1:0] pass_cnt_reg;
    logic                stop_reg;
    logic [DRAIN_W-1:0]  drain_cnt_reg;
    logic [1:0]          sel_reg, sel_next;
    logic                busy_reg, busy_next;
    logic                pass_done_reg, pass_done_next;
    logic                done_reg, done_next;

    logic [DWELL_W-1:0]  dwell_eff;
    logic [1:0]          first_ch;
    logic [1:0]          next_ch;
    logic                accept;
    logic                last_dwell;
    logic                wrap;
    logic                pass_limit;
    logic                end_scan;
    logic                drain_last;

    assign dwell_eff  = (dwell == '0) ? DWELL_ONE : dwell;
    assign accept     = (state_reg == IDLE) && start && (chan_en != 4'd0);
    assign last_dwell = (state_reg == SCAN) && (dwell_cnt_reg == DWELL_ONE);
    // The next channel at or below the current one means the sweep just finished,
    // which also covers the single-enabled-channel case.
    assign wrap       = (next_ch <= sel_reg);
    assign pass_limit = (passes_reg != '0) && ((pass_cnt_reg + PASS_ONE) == passes_reg);
    // A stop arriving in the last dwell cycle itself still ends the scan here.
    assign end_scan   = last_dwell && ((wrap && pass_limit) || stop_reg || stop);
    assign drain_last = (state_reg == DRAIN) && (drain_cnt_reg == DRAIN_LAST);

    // Lowest enabled channel of the incoming mask.
    always_comb begin
        first_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (chan_en[i]) first_ch = 2'(i);
        end
    end

    // Nearest enabled channel above sel_reg, modulo 4; falls back to sel_reg itself.
    always_comb begin
        next_ch = sel_reg;
        for (int i = 3; i >= 1; i--) begin
            if (mask_reg[sel_reg + 2'(i)]) next_ch = sel_reg + 2'(i);
        end
    end

    // State register and scan datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            mask_reg      <= 4'd0;
            dwell_len_reg <= '0;
            dwell_cnt_reg <= '0;
            passes_reg    <= '0;
            pass_cnt_reg  <= '0;
            stop_reg      <= 1'b0;
            drain_cnt_reg <= '0;
            sel_reg       <= 2'd0;
            busy_reg      <= 1'b0;
            pass_done_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sel_reg       <= sel_next;
            busy_reg      <= busy_next;
            pass_done_reg <= pass_done_next;
            done_reg      <= done_next;

            if (accept) begin
                mask_reg      <= chan_en;
                dwell_len_reg <= dwell_eff;
                dwell_cnt_reg <= dwell_eff;
                passes_reg    <= passes;
                pass_cnt_reg  <= '0;
                stop_reg      <= 1'b0;
            end else if (state_reg == SCAN) begin
                if (stop) stop_reg <= 1'b1;
                if (last_dwell) begin
                    dwell_cnt_reg <= dwell_len_reg;
                    // Saturate so continuous scans never wrap the pass count.
                    if (wrap && (pass_cnt_reg != PASS_MAX)) pass_cnt_reg <= pass_cnt_reg + PASS_ONE;
                end else begin
                    dwell_cnt_reg <= dwell_cnt_reg - DWELL_ONE;
                end
            end

            drain_cnt_reg <= (state_reg == DRAIN) ? drain_cnt_reg + DRAIN_ONE : '0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)     state_next = SCAN;
            SCAN:    if (end_scan)   state_next = DRAIN;
            DRAIN:   if (drain_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic; every output is registered from these next values.
    always_comb begin
        sel_next       = sel_reg;
        if (accept) begin
            sel_next = first_ch;
        end else if (last_dwell && !end_scan) begin
            sel_next = next_ch;
        end
        busy_next      = (state_next != IDLE);
        pass_done_next = last_dwell && wrap;
        done_next      = drain_last;
    end

    // Tag pipeline: the channel of each completed dwell emerges MUX_LAT cycles later.
    genvar gi;
    generate
        for (gi = 0; gi < MUX_LAT; gi++) begin : g_pipe
            logic       v_reg;
            logic [1:0] ch_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        v_reg  <= 1'b0;
                        ch_reg <= 2'd0;
                    end else begin
                        v_reg <= last_dwell;
                        if (last_dwell) ch_reg <= sel_reg;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        v_reg  <= 1'b0;
                        ch_reg <= 2'd0;
                    end else begin
                        v_reg  <= g_pipe[gi-1].v_reg;
                        ch_reg <= g_pipe[gi-1].ch_reg;
                    end
                end
            end
        end
    endgenerate

    assign sel        = sel_reg;
    assign busy       = busy_reg;
    assign samp_valid = g_pipe[MUX_LAT-1].v_reg;
    assign samp_ch    = g_pipe[MUX_LAT-1].ch_reg;
    assign pass_done  = pass_done_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Testbench for mux_sel_scanner: directed scenarios plus randomized traffic. A
// schedule model predicts every output from the arithmetic of dwell slots.
module tb_mux_sel_scanner;

    localparam int LAT = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] chan_en = 4'd0;
    logic [7:0] dwell = 8'd0;
    logic [3:0] passes = 4'd0;
    logic [1:0] sel;
    logic       busy;
    logic       samp_valid;
    logic [1:0] samp_ch;
    logic       pass_done;
    logic       done;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    // Output counters gathered every cycle, cleared by the directed tests.
    int cnt_sv = 0;
    int cnt_pd = 0;
    int cnt_dn = 0;
    int last_ch = -1;

    // Schedule model: a scan started in cycle m_ts occupies slots of m_d cycles.
    // Slot j covers relative cycles [j*m_d, (j+1)*m_d) with r = t - m_ts - 1, and
    // uses channel m_chs[j % m_len]. m_n is the number of slots the scan will run.
    bit         m_has = 1'b0;
    int         m_ts = 0;
    int         m_d = 1;
    int         m_n = 0;
    int         m_len = 1;
    int         m_chs [4];
    logic [1:0] m_prev_sel = 2'd0;

    mux_sel_scanner #(
        .DWELL_W (8),
        .PASSES_W(4),
        .MUX_LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .chan_en   (chan_en),
        .dwell     (dwell),
        .passes    (passes),
        .sel       (sel),
        .busy      (busy),
        .samp_valid(samp_valid),
        .samp_ch   (samp_ch),
        .pass_done (pass_done),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs of cycle t packed as {sel[1:0], busy, sv, ch[1:0], pd, done}.
    function automatic logic [7:0] model_out(int t);
        logic [1:0] s;
        logic [1:0] sc;
        logic       b, v, p, d;
        int         r, total, u, j;
        s = m_prev_sel; sc = 2'd0; b = 1'b0; v = 1'b0; p = 1'b0; d = 1'b0;
        if (m_has) begin
            r     = t - m_ts - 1;
            total = m_n * m_d;
            if (r >= 0) begin
                if (r < total) s = 2'(m_chs[(r / m_d) % m_len]);
                else           s = 2'(m_chs[(m_n - 1) % m_len]);
                b = (r < total + LAT);
                u = r - LAT + 1;
                if (u > 0 && (u % m_d) == 0) begin
                    j = u / m_d - 1;
                    if (j < m_n) begin
                        v  = 1'b1;
                        sc = 2'(m_chs[j % m_len]);
                    end
                end
                if (r > 0 && (r % m_d) == 0) begin
                    j = r / m_d - 1;
                    if (j < m_n && (j % m_len) == m_len - 1) p = 1'b1;
                end
                d = (r == total + LAT);
            end
        end
        return {s, b, v, sc, p, d};
    endfunction

    task automatic check(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic [7:0] e;
        e = rst_n ? model_out(cyc) : 8'd0;
        check("sel", int'(sel), int'(e[7:6]));
        check("busy", int'(busy), int'(e[5]));
        check("samp_valid", int'(samp_valid), int'(e[4]));
        if (e[4] || !rst_n) check("samp_ch", int'(samp_ch), int'(e[3:2]));
        check("pass_done", int'(pass_done), int'(e[1]));
        check("done", int'(done), int'(e[0]));
        if (samp_valid) begin
            cnt_sv++;
            last_ch = int'(samp_ch);
        end
        if (pass_done) cnt_pd++;
        if (done) cnt_dn++;
    end

    task automatic clear_counts();
        cnt_sv = 0; cnt_pd = 0; cnt_dn = 0; last_ch = -1;
    endtask

    // Apply this cycle's inputs and let the model see them.
    task automatic cycle_in(bit st, bit sp, logic [3:0] en, logic [7:0] dw, logic [3:0] ps);
        logic [7:0] o;
        int         r, total;
        @(negedge clk);
        #1;
        start = st; stop = sp; chan_en = en; dwell = dw; passes = ps;
        if (rst_n) begin
            o = model_out(cyc);
            if (sp && m_has) begin
                r     = cyc - m_ts - 1;
                total = m_n * m_d;
                if (r >= 0 && r < total && (r / m_d + 1) < m_n) m_n = r / m_d + 1;
            end
            if (st && en != 4'd0 && !o[5]) begin
                m_prev_sel = o[7:6];
                m_len = 0;
                for (int i = 0; i < 4; i++) begin
                    if (en[i]) begin
                        m_chs[m_len] = i;
                        m_len++;
                    end
                end
                m_d   = (dw == 8'd0) ? 1 : int'(dw);
                m_n   = (ps == 4'd0) ? (1 << 20) : int'(ps) * m_len;
                m_ts  = cyc;
                m_has = 1'b1;
            end
        end
    endtask

    task automatic idle_cycle();
        cycle_in(1'b0, 1'b0, 4'($urandom), 8'($urandom), 4'($urandom));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            idle_cycle();
            if (!model_out(cyc)[5]) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_idle_timeout cyc=%0d got=busy expected=idle", cyc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        start = 1'b0; stop = 1'b0;
        rst_n = 1'b0;
        m_has = 1'b0;
        m_prev_sel = 2'd0;
        #1;
        check("rst_sel", int'(sel), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_samp_valid", int'(samp_valid), 0);
        check("rst_samp_ch", int'(samp_ch), 0);
        check("rst_pass_done", int'(pass_done), 0);
        check("rst_done", int'(done), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Hand-derived waveform for chan_en=1011, dwell=3, passes=1, indexed by cycles after start.
    int t1_sel  [12] = '{0, 0, 0, 0, 1, 1, 1, 3, 3, 3, 3, 3};
    int t1_busy [12] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int t1_sv   [12] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
    int t1_ch   [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0};
    int t1_pd   [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int t1_dn   [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycle();

        // Test 1: literal waveform.
        cycle_in(1'b1, 1'b0, 4'b1011, 8'd3, 4'd1);
        for (int k = 1; k < 12; k++) begin
            idle_cycle();
            check("t1_sel", int'(sel), t1_sel[k]);
            check("t1_busy", int'(busy), t1_busy[k]);
            check("t1_samp_valid", int'(samp_valid), t1_sv[k]);
            if (t1_sv[k] != 0) check("t1_samp_ch", int'(samp_ch), t1_ch[k]);
            check("t1_pass_done", int'(pass_done), t1_pd[k]);
            check("t1_done", int'(done), t1_dn[k]);
        end
        wait_idle();

        // Test 2: single channel, dwell 1, two passes.
        clear_counts();
        cycle_in(1'b1, 1'b0, 4'b0100, 8'd1, 4'd2);
        wait_idle();
        idle_cycle();
        check("t2_samples", cnt_sv, 2);
        check("t2_last_ch", last_ch, 2);
        check("t2_pass_done", cnt_pd, 2);
        check("t2_done", cnt_dn, 1);

        // Test 3: dwell 0 behaves as 1.
        clear_counts();
        cycle_in(1'b1, 1'b0, 4'b0011, 8'd0, 4'd1);
        idle_cycle();
        check("t3_sel_first", int'(sel), 0);
        idle_cycle();
        check("t3_sel_second", int'(sel), 1);
        wait_idle();
        idle_cycle();
        check("t3_samples", cnt_sv, 2);
        check("t3_last_ch", last_ch, 1);
        check("t3_done", cnt_dn, 1);

        // Test 4: continuous scan stopped in the second cycle of the channel 2 dwell.
        clear_counts();
        cycle_in(1'b1, 1'b0, 4'b1111, 8'd4, 4'd0);
        for (int k = 1; k < 10; k++) idle_cycle();
        cycle_in(1'b0, 1'b1, 4'b1111, 8'd4, 4'd0);
        wait_idle();
        idle_cycle();
        check("t4_samples", cnt_sv, 3);
        check("t4_last_ch", last_ch, 2);
        check("t4_pass_done", cnt_pd, 0);
        check("t4_done", cnt_dn, 1);

        // Test 5: empty mask ignored; start while busy does not restart.
        clear_counts();
        cycle_in(1'b1, 1'b0, 4'b0000, 8'd3, 4'd1);
        for (int k = 0; k < 4; k++) begin
            idle_cycle();
            check("t5_busy_empty", int'(busy), 0);
        end
        cycle_in(1'b1, 1'b0, 4'b0001, 8'd2, 4'd1);
        idle_cycle();
        cycle_in(1'b1, 1'b0, 4'b1000, 8'd5, 4'd3);
        wait_idle();
        idle_cycle();
        check("t5_samples", cnt_sv, 1);
        check("t5_last_ch", last_ch, 0);
        check("t5_done", cnt_dn, 1);

        // Test 6: reset in the middle of a scan.
        cycle_in(1'b1, 1'b0, 4'b1111, 8'd3, 4'd0);
        for (int k = 0; k < 3; k++) idle_cycle();
        check("t6_busy_before", int'(busy), 1);
        do_reset();
        clear_counts();
        for (int k = 0; k < 20; k++) idle_cycle();
        check("t6_samples_after", cnt_sv, 0);
        check("t6_done_after", cnt_dn, 0);

        // Randomized traffic.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                do_reset();
            end else begin
                cycle_in($urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0,
                         4'($urandom), 8'($urandom_range(0, 4)), 4'($urandom_range(0, 3)));
            end
        end
        cycle_in(1'b0, 1'b1, 4'd0, 8'd0, 4'd0);
        wait_idle();
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
